// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: collective (SCAN) elevator controller for NUM_FLOORS floors.
// Latches car, hall-up and hall-down calls. Keeps travelling in one direction
// while calls remain ahead, then reverses. Door and travel timing come from
// internal down-counters.
module elevator_ctrl_n #(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 10,
  parameter int DOOR_CYCLES   = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] car_call,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_dn,
  input  logic                  door_hold,
  input  logic                  enable,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  stop,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;

  localparam logic [FLOOR_W-1:0]    TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0]    BOT_FLOOR   = '0;
  localparam logic [NUM_FLOORS-1:0] UP_MASK     = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK     = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [TW-1:0]         TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]         DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

  logic [1:0]            state, state_nx;
  logic [FLOOR_W-1:0]    floor_nx, next_floor, entry_floor;
  logic                  dir_nx, arrive_nx, enter_door;
  logic [TW-1:0]         travel_tmr, travel_nx;
  logic [DW-1:0]         door_tmr, door_nx;
  logic [NUM_FLOORS-1:0] car_q, up_q, dn_q;
  logic [NUM_FLOORS-1:0] car_in, up_in, dn_in;
  logic [NUM_FLOORS-1:0] clr_car, clr_up, clr_dn;
  logic [NUM_FLOORS-1:0] here_bit, next_bit, entry_bit;
  logic                  call_here;

  // One-hot vector selecting floor f.
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i == int'(f)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // True when any call lies strictly beyond floor f in direction up.
  function automatic logic calls_ahead(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]    f,
                                       input logic                  up);
    logic found;
    found = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) found = 1'b1;
    end
    return found;
  endfunction

  assign pending   = car_q | up_q | dn_q;
  assign moving    = (state == S_MOVE);
  assign door_open = (state == S_DOOR);
  assign stop      = (state == S_IDLE);

  // Filter incoming calls: drop the meaningless hall bits, and while the door is open
  // turn a call for this floor into a door-timer reload instead of a latched call.
  always_comb begin
    here_bit  = floor_bit(floor);
    car_in    = car_call;
    up_in     = hall_up & UP_MASK;
    dn_in     = hall_dn & DN_MASK;
    call_here = 1'b0;
    if (state == S_DOOR) begin
      call_here = |((car_in | up_in | dn_in) & here_bit);
      car_in    = car_in & ~here_bit;
      up_in     = up_in & ~here_bit;
      dn_in     = dn_in & ~here_bit;
    end
  end

  // Dispatch, timers, and the call clears applied each time the door opens at a floor.
  always_comb begin
    state_nx    = state;
    floor_nx    = floor;
    dir_nx      = dir_up;
    travel_nx   = travel_tmr;
    door_nx     = door_tmr;
    arrive_nx   = 1'b0;
    enter_door  = 1'b0;
    entry_floor = floor;
    next_floor  = floor;
    next_bit    = '0;
    entry_bit   = '0;
    clr_car     = '0;
    clr_up      = '0;
    clr_dn      = '0;

    case (state)
      S_IDLE: begin
        if (enable && |(pending & here_bit)) begin
          enter_door = 1'b1;
        end else if (enable && |pending) begin
          if (!calls_ahead(pending, floor, dir_up)) dir_nx = ~dir_up;
          state_nx  = S_MOVE;
          travel_nx = TRAVEL_LOAD;
        end
      end
      S_MOVE: begin
        if (travel_tmr != '0) begin
          travel_nx = travel_tmr - TW'(1);
        end else begin
          next_floor = dir_up ? (floor + FLOOR_W'(1)) : (floor - FLOOR_W'(1));
          next_bit   = floor_bit(next_floor);
          floor_nx   = next_floor;
          arrive_nx  = 1'b1;
          if (|(car_q & next_bit) ||
              (dir_up ? |(up_q & next_bit) : |(dn_q & next_bit)) ||
              !calls_ahead(pending, next_floor, dir_up) || !enable) begin
            enter_door  = 1'b1;
            entry_floor = next_floor;
          end else begin
            travel_nx = TRAVEL_LOAD;
          end
        end
      end
      S_DOOR: begin
        if (door_hold || call_here) begin
          door_nx = DOOR_LOAD;
        end else if (door_tmr != '0) begin
          door_nx = door_tmr - DW'(1);
        end else if (!enable || !(|pending)) begin
          state_nx = S_IDLE;
        end else begin
          if (!calls_ahead(pending, floor, dir_up)) dir_nx = ~dir_up;
          state_nx  = S_MOVE;
          travel_nx = TRAVEL_LOAD;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (enter_door) begin
      state_nx  = S_DOOR;
      door_nx   = DOOR_LOAD;
      entry_bit = floor_bit(entry_floor);
      clr_car   = entry_bit;
      if (dir_up) clr_up = entry_bit;
      else        clr_dn = entry_bit;
      if (!calls_ahead(pending, entry_floor, dir_up)) begin
        dir_nx = ~dir_up;
        clr_up = entry_bit;
        clr_dn = entry_bit;
      end
      if (entry_floor == TOP_FLOOR)      dir_nx = 1'b0;
      else if (entry_floor == BOT_FLOOR) dir_nx = 1'b1;
    end
  end

  // State, position, timers and call latches; a clear at the door floor beats a new call there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      floor      <= '0;
      dir_up     <= 1'b1;
      arrive     <= 1'b0;
      travel_tmr <= '0;
      door_tmr   <= '0;
      car_q      <= '0;
      up_q       <= '0;
      dn_q       <= '0;
    end else begin
      state      <= state_nx;
      floor      <= floor_nx;
      dir_up     <= dir_nx;
      arrive     <= arrive_nx;
      travel_tmr <= travel_nx;
      door_tmr   <= door_nx;
      car_q      <= (car_q | car_in) & ~clr_car;
      up_q       <= (up_q | up_in) & ~clr_up;
      dn_q       <= (dn_q | dn_in) & ~clr_dn;
    end
  end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: directed scenarios plus random calls for elevator_ctrl_n.
// A floor-and-calls reference model predicts arrival and door-close events into
// queues; a separate monitor compares them with what the controller shows.
module tb_elevator_ctrl_n;

  localparam int NF = 4;
  localparam int FW = 2;
  localparam int TC = 4;
  localparam int DC = 3;

  localparam int PH_IDLE = 0;
  localparam int PH_MOVE = 1;
  localparam int PH_DOOR = 2;

  typedef struct {
    int       cyc;
    int       fl;
    bit       door;
    bit       dir;
    bit [3:0] pend;
  } arr_ev_t;

  typedef struct {
    int       cyc;
    bit       mv;
    int       fl;
    bit       dir;
    bit [3:0] pend;
  } close_ev_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NF-1:0] car_call = '0;
  logic [NF-1:0] hall_up = '0;
  logic [NF-1:0] hall_dn = '0;
  logic          door_hold = 1'b0;
  logic          enable = 1'b1;
  logic [FW-1:0] floor;
  logic          dir_up, moving, door_open, stop, arrive;
  logic [NF-1:0] pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  int       m_fl, m_ph, m_left;
  bit       m_dir;
  bit [3:0] m_car, m_up, m_dn;

  arr_ev_t   arrq[$];
  close_ev_t closeq[$];

  elevator_ctrl_n #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .car_call(car_call), .hall_up(hall_up),
    .hall_dn(hall_dn), .door_hold(door_hold), .enable(enable), .floor(floor),
    .dir_up(dir_up), .moving(moving), .door_open(door_open), .stop(stop),
    .arrive(arrive), .pending(pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit has_ahead(input bit [3:0] p, input int f, input bit up);
    for (int i = 0; i < NF; i++) begin
      if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic modelReset();
    m_fl = 0; m_dir = 1'b1; m_ph = PH_IDLE; m_left = 0;
    m_car = '0; m_up = '0; m_dn = '0;
  endtask

  // Advance the reference by one clock edge given the inputs present at that edge.
  task automatic modelStep(input bit [3:0] cc, input bit [3:0] hu, input bit [3:0] hd,
                           input bit hold, input bit en);
    bit [3:0] pre, req, hum, hdm;
    bit       enter, push_arr, push_close, was_door;
    int       pre_fl;
    arr_ev_t   a;
    close_ev_t c;
    pre = m_car | m_up | m_dn;
    hum = hu & 4'b0111;
    hdm = hd & 4'b1110;
    req = cc | hum | hdm;
    enter = 0; push_arr = 0; push_close = 0;
    was_door = (m_ph == PH_DOOR);
    pre_fl = m_fl;
    case (m_ph)
      PH_IDLE: begin
        if (en && pre[m_fl]) enter = 1;
        else if (en && pre != 0) begin
          if (!has_ahead(pre, m_fl, m_dir)) m_dir = !m_dir;
          m_ph = PH_MOVE; m_left = TC;
        end
      end
      PH_MOVE: begin
        m_left--;
        if (m_left == 0) begin
          m_fl = m_fl + (m_dir ? 1 : -1);
          push_arr = 1;
          if (m_car[m_fl] || (m_dir ? m_up[m_fl] : m_dn[m_fl]) ||
              !has_ahead(pre, m_fl, m_dir) || !en) enter = 1;
          else m_left = TC;
        end
      end
      default: begin
        if (hold || req[m_fl]) m_left = DC;
        else begin
          m_left--;
          if (m_left == 0) begin
            push_close = 1;
            if (!en || pre == 0) m_ph = PH_IDLE;
            else begin
              if (!has_ahead(pre, m_fl, m_dir)) m_dir = !m_dir;
              m_ph = PH_MOVE; m_left = TC;
            end
          end
        end
      end
    endcase
    for (int i = 0; i < NF; i++) begin
      if (!(was_door && i == pre_fl)) begin
        if (cc[i])  m_car[i] = 1;
        if (hum[i]) m_up[i] = 1;
        if (hdm[i]) m_dn[i] = 1;
      end
    end
    if (enter) begin
      m_car[m_fl] = 0;
      if (m_dir) m_up[m_fl] = 0; else m_dn[m_fl] = 0;
      if (!has_ahead(pre, m_fl, m_dir)) begin
        m_dir = !m_dir; m_up[m_fl] = 0; m_dn[m_fl] = 0;
      end
      if (m_fl == NF - 1) m_dir = 0;
      else if (m_fl == 0) m_dir = 1;
      m_ph = PH_DOOR; m_left = DC;
    end
    if (push_arr) begin
      a.cyc = cyc + 1; a.fl = m_fl; a.door = enter; a.dir = m_dir;
      a.pend = m_car | m_up | m_dn;
      arrq.push_back(a);
    end
    if (push_close) begin
      c.cyc = cyc + 1; c.mv = (m_ph == PH_MOVE); c.fl = m_fl; c.dir = m_dir;
      c.pend = m_car | m_up | m_dn;
      closeq.push_back(c);
    end
  endtask

  task automatic applyStimulus(input bit [3:0] cc, input bit [3:0] hu, input bit [3:0] hd,
                               input bit hold, input bit en);
    @(negedge clk);
    car_call = cc; hall_up = hu; hall_dn = hd; door_hold = hold; enable = en;
    modelStep(cc, hu, hd, hold, en);
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n, input bit en);
    for (int k = 0; k < n; k++) applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, en);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    mon_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    car_call = '0; hall_up = '0; hall_dn = '0; door_hold = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    modelReset();
    arrq.delete();
    closeq.delete();
    reset_n = 1'b1;
    mon_en = 1'b1;
    modelStep(4'b0, 4'b0, 4'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops predicted events whenever the controller arrives or closes its door.
  initial begin : monitor
    bit prev_door;
    arr_ev_t   a;
    close_ev_t c;
    prev_door = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        prev_door = 1'b0;
      end else begin
        if (arrive) begin
          checks++;
          if (arrq.size() == 0) begin
            errors++;
            $display("[TB] FAIL arrive_unexpected: cycle %0d floor %0d, none expected", cyc, floor);
          end else begin
            a = arrq.pop_front();
            if (a.cyc != cyc || a.fl != int'(floor) || a.door != door_open ||
                a.dir != dir_up || a.pend != pending) begin
              errors++;
              $display("[TB] FAIL arrive_event: got cyc %0d fl %0d door %0b dir %0b pend %b, expected cyc %0d fl %0d door %0b dir %0b pend %b",
                       cyc, floor, door_open, dir_up, pending, a.cyc, a.fl, a.door, a.dir, a.pend);
            end
          end
        end else if (arrq.size() > 0 && arrq[0].cyc <= cyc) begin
          checks++;
          errors++;
          a = arrq.pop_front();
          $display("[TB] FAIL arrive_missed: no pulse at cycle %0d, expected arrival at floor %0d", cyc, a.fl);
        end
        if (prev_door && !door_open) begin
          checks++;
          if (closeq.size() == 0) begin
            errors++;
            $display("[TB] FAIL close_unexpected: door closed at cycle %0d floor %0d, none expected", cyc, floor);
          end else begin
            c = closeq.pop_front();
            if (c.cyc != cyc || c.mv != moving || c.mv == stop || c.fl != int'(floor) ||
                c.dir != dir_up || c.pend != pending) begin
              errors++;
              $display("[TB] FAIL close_event: got cyc %0d mv %0b stop %0b fl %0d dir %0b pend %b, expected cyc %0d mv %0b fl %0d dir %0b pend %b",
                       cyc, moving, stop, floor, dir_up, pending, c.cyc, c.mv, c.fl, c.dir, c.pend);
            end
          end
        end else if (closeq.size() > 0 && closeq[0].cyc <= cyc) begin
          checks++;
          errors++;
          c = closeq.pop_front();
          $display("[TB] FAIL close_missed: door still %0b at cycle %0d, expected close at floor %0d", door_open, cyc, c.fl);
        end
        prev_door = door_open;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit [3:0] cc, hu, hd;
    modelReset();

    // Scenario 1: single car call to the top floor.
    doReset();
    checkOutput("reset_floor", int'(floor), 0);
    checkOutput("reset_dir_up", int'(dir_up), 1);
    checkOutput("reset_moving", int'(moving), 0);
    checkOutput("reset_door_open", int'(door_open), 0);
    checkOutput("reset_stop", int'(stop), 1);
    checkOutput("reset_arrive", int'(arrive), 0);
    checkOutput("reset_pending", int'(pending), 0);
    applyStimulus(4'b1000, 4'b0, 4'b0, 1'b0, 1'b1);
    checkOutput("s1_pending_next", int'(pending), 8);
    checkOutput("s1_not_moving_yet", int'(moving), 0);
    runCycles(1, 1'b1);
    checkOutput("s1_moving", int'(moving), 1);
    runCycles(16, 1'b1);
    checkOutput("s1_floor_top", int'(floor), 3);
    checkOutput("s1_stop", int'(stop), 1);
    checkOutput("s1_dir_down", int'(dir_up), 0);
    checkOutput("s1_pending_clear", int'(pending), 0);

    // Scenario 2: hall calls collected in SCAN order.
    doReset();
    applyStimulus(4'b0, 4'b0, 4'b0010, 1'b0, 1'b1);
    applyStimulus(4'b0, 4'b0100, 4'b0, 1'b0, 1'b1);
    runCycles(4, 1'b1);
    checkOutput("s2_pass_floor1", int'(floor), 1);
    checkOutput("s2_pass_no_door", int'(door_open), 0);
    checkOutput("s2_pass_moving", int'(moving), 1);
    runCycles(4, 1'b1);
    checkOutput("s2_stop_floor2", int'(floor), 2);
    checkOutput("s2_door2", int'(door_open), 1);
    checkOutput("s2_dir_flip", int'(dir_up), 0);
    checkOutput("s2_pending_after2", int'(pending), 2);
    runCycles(7, 1'b1);
    checkOutput("s2_stop_floor1", int'(floor), 1);
    checkOutput("s2_door1", int'(door_open), 1);
    checkOutput("s2_pending_empty", int'(pending), 0);
    runCycles(3, 1'b1);

    // Scenario 3: door hold at floor 2.
    applyStimulus(4'b0100, 4'b0, 4'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20 && !door_open; k++) runCycles(1, 1'b1);
    checkOutput("s3_reach_door", int'(door_open), 1);
    repeat (10) applyStimulus(4'b0, 4'b0, 4'b0, 1'b1, 1'b1);
    checkOutput("s3_held_open", int'(door_open), 1);
    checkOutput("s3_floor", int'(floor), 2);
    runCycles(2, 1'b1);
    checkOutput("s3_open_after_release", int'(door_open), 1);
    runCycles(1, 1'b1);
    checkOutput("s3_closed", int'(door_open), 0);
    checkOutput("s3_stop", int'(stop), 1);

    // Scenario 4: enable dropped during the segment toward floor 2.
    doReset();
    applyStimulus(4'b1000, 4'b0, 4'b0, 1'b0, 1'b1);
    runCycles(6, 1'b1);
    runCycles(10, 1'b0);
    checkOutput("s4_floor2", int'(floor), 2);
    checkOutput("s4_stop", int'(stop), 1);
    checkOutput("s4_pending_kept", int'(pending), 8);
    runCycles(1, 1'b1);
    checkOutput("s4_resume_moving", int'(moving), 1);
    runCycles(8, 1'b1);
    checkOutput("s4_floor3", int'(floor), 3);

    // Scenario 5: asynchronous reset in the middle of a travel segment.
    doReset();
    applyStimulus(4'b0100, 4'b0, 4'b0, 1'b0, 1'b1);
    runCycles(7, 1'b1);
    checkOutput("s5_pre_moving", int'(moving), 1);
    checkOutput("s5_pre_floor", int'(floor), 1);
    #2;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("s5_async_floor", int'(floor), 0);
    checkOutput("s5_async_moving", int'(moving), 0);
    checkOutput("s5_async_stop", int'(stop), 1);
    checkOutput("s5_async_dir", int'(dir_up), 1);
    checkOutput("s5_async_pending", int'(pending), 0);
    doReset();
    checkOutput("s5_pending_after", int'(pending), 0);

    // Scenario 6: call for the open-door floor reloads the door timer.
    doReset();
    applyStimulus(4'b0010, 4'b0, 4'b0, 1'b0, 1'b1);
    runCycles(5, 1'b1);
    checkOutput("s6_door_floor1", int'(door_open), 1);
    applyStimulus(4'b0010, 4'b0, 4'b0, 1'b0, 1'b1);
    checkOutput("s6_not_latched", int'(pending), 0);
    runCycles(2, 1'b1);
    checkOutput("s6_still_open", int'(door_open), 1);
    runCycles(1, 1'b1);
    checkOutput("s6_closed", int'(door_open), 0);

    // Random traffic against the reference model.
    doReset();
    for (int n = 0; n < 1500; n++) begin
      cc = '0; hu = '0; hd = '0;
      for (int b = 0; b < NF; b++) begin
        if ($urandom_range(0, 24) == 0) cc[b] = 1'b1;
        if ($urandom_range(0, 24) == 0) hu[b] = 1'b1;
        if ($urandom_range(0, 24) == 0) hd[b] = 1'b1;
      end
      applyStimulus(cc, hu, hd, $urandom_range(0, 14) == 0, $urandom_range(0, 19) != 0);
    end
    runCycles(2, 1'b1);
    checkOutput("queues_drained", arrq.size() + closeq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
- Parametrised successor of the 4-floor elevator FSM. Serves NUM_FLOORS floors with a latched call register covering car calls, hall-up calls and hall-down calls.
- Uses collective (SCAN) dispatch: keeps the current direction while calls remain ahead, then reverses.
- Door and travel timers are internal counters, replacing the external clock/delay handshake.
- Sits between the button/debounce front end and the floor display/motor driver.

Parameters:
- NUM_FLOORS, 4, number of floors (minimum 2).
- FLOOR_W, 2, width of floor index; must satisfy 2**FLOOR_W >= NUM_FLOORS.
- TRAVEL_CYCLES, 10, clock cycles to travel between adjacent floors (minimum 1).
- DOOR_CYCLES, 10, clock cycles the door stays open with no hold (minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- car_call  in  NUM_FLOORS  car-panel request, one bit per floor, level or pulse.
- hall_up  in  NUM_FLOORS  hall up-call per floor; bit NUM_FLOORS-1 ignored.
- hall_dn  in  NUM_FLOORS  hall down-call per floor; bit 0 ignored.
- door_hold  in  1  open/close request; 1 keeps door open.
- enable  in  1  1 = may leave IDLE or DOOR_OPEN toward another floor.
- floor  out  FLOOR_W  current floor index.
- dir_up  out  1  current/last travel direction; 1 = up.
- moving  out  1  1 while in MOVE.
- door_open  out  1  1 while in DOOR_OPEN.
- stop  out  1  1 while in IDLE.
- arrive  out  1  one-cycle pulse on every floor index update.
- pending  out  NUM_FLOORS  OR of latched car, up and down calls per floor.

Behaviour:
- Reset (async, reset_n=0), held until release:
  - state=IDLE, floor=0, dir_up=1, moving=0, door_open=0, stop=1, arrive=0.
  - All call latches and both timers = 0.
- Call latching:
  - Each edge, set latch bits from inputs; pending reflects a call the cycle after it is asserted.
  - A call for the current floor while in DOOR_OPEN is not latched; it reloads the door timer instead.
- "Ahead": any pending bit strictly above floor when dir_up=1, strictly below floor when dir_up=0.
- IDLE (stop=1):
  - If enable=1 and a call exists at the current floor: go to DOOR_OPEN.
  - Else if enable=1 and any pending bit is set: if nothing is ahead, flip dir_up first; then go to MOVE with travel timer = TRAVEL_CYCLES-1.
  - So moving asserts 2 cycles after a call pulse.
- MOVE (moving=1):
  - Timer decrements each cycle.
  - On the edge where timer==0: floor +/-1 and arrive=1 for one cycle.
  - Stop at the new floor if: a car call is there, OR a hall call in dir_up's direction is there, OR nothing is ahead of the new floor, OR enable=0. Stopping enters DOOR_OPEN on that same edge.
  - Otherwise reload the timer and stay in MOVE.
  - MOVE therefore lasts exactly TRAVEL_CYCLES cycles per floor.
  - enable=0 never aborts a segment in progress.
- DOOR_OPEN entry (door_open=1, door timer = DOOR_CYCLES-1):
  - Clear the car call and the same-direction hall call at this floor.
  - If nothing is ahead, flip dir_up and also clear the opposite hall call.
- DOOR_OPEN:
  - door_hold=1 reloads the door timer.
  - On timer==0 with door_hold=0: if enable=0 or no pending bit is set, go to IDLE. Otherwise apply the IDLE direction rule and go to MOVE.
- Floor bounds:
  - floor never leaves 0..NUM_FLOORS-1; direction logic guarantees this.
  - At the top floor dir_up is forced to 0 on arrival; at floor 0 it is forced to 1.
- Simultaneous events:
  - A call arriving on the same edge a latch is cleared: the new call wins only if it is for a different floor.
  - Hall calls on ignored bits (top up, bottom down) are dropped.
- Reset mid-MOVE or mid-DOOR_OPEN: immediate return to the reset values; all calls are lost.

Test Plan:
Bench parameters for all scenarios: NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3, enable=1.
1. Reset, pulse car_call[3] -> pending=4'b1000 next cycle; moving one cycle later; floor=1,2,3 at 4-cycle intervals, each with an arrive pulse; door_open=1 at floor 3 for 3 cycles; then stop=1 with dir_up=0 and pending=0.
2. From floor 0 moving up, pulse hall_dn[1] then hall_up[2] -> passes floor 1 without stopping; stops at 2, clearing up-call bit 2; no calls ahead, so dir_up flips to 0; then stops at 1 and clears bit 1.
3. door_hold=1 for 10 cycles at floor 2 -> door_open stays 1 for the whole hold plus 3 cycles after release; floor unchanged.
4. Drop enable to 0 during the second MOVE cycle toward floor 2 -> floor=2 reached, door opens 3 cycles, then IDLE with stop=1 while car_call[3] stays pending; raising enable resumes toward floor 3.
5. Assert reset_n=0 asynchronously mid-MOVE (timer=1) -> all outputs at reset values immediately; pending=0 after release.
6. With the door open at floor 1, pulse car_call[1] -> not latched; door timer reloads to 2; pending[1] stays 0.
